bp_me_nonsynth_lce_req_tracker: RTL and testbench
=================================================

// Module: bp_me_nonsynth_lce_req_tracker
// PURPOSE
// - Non-synthesizable monitor on one LCE's BedRock interface.
// - Records each accepted LCE request in a small table and retires it when the matching command arrives.
// - Produces cache_req_complete_o and uc_store_req_complete_o; these drive the LCE tracer's completion inputs.
// - Flags timeouts, table overflow and unmatched completions.
// PARAMETERS
// - bp_params_p        e_bp_unicore_half_cfg  processor config; supplies paddr_width_p, lce_id_width_p, cce_block_width_p
// - max_outstanding_p  4                      table entries, >=1
// - timeout_p          10000                  cycles before an outstanding entry is reported as timed out
// - block_width_p      cce_block_width_p      bits per block; block offset = clog2(block_width_p/8)
// PORTS
// - clk_i                    in   1         clock
// - reset_i                  in   1         synchronous, active-high reset
// - lce_id_i                 in   lce_id_w  LCE id being monitored
// - lce_req_i                in   req_msg_w bp_bedrock_lce_req_msg_s
// - lce_req_v_i              in   1         request valid
// - lce_req_ready_and_i      in   1         request ready
// - lce_cmd_i                in   cmd_msg_w bp_bedrock_lce_cmd_msg_s (to LCE)
// - lce_cmd_v_i              in   1         command valid
// - lce_cmd_ready_and_i      in   1         command ready
// - cache_req_complete_o     out  1         1-cycle pulse: cached or uncached-load request retired
// - uc_store_req_complete_o  out  1         1-cycle pulse: uncached store retired
// - outstanding_o            out  clog2(max_outstanding_p+1)  count of valid entries
// - timeout_o                out  1         sticky; an entry reached timeout_p
// - overflow_o               out  1         sticky; request accepted while table full
// - unmatched_o              out  1         sticky; completion command matched no entry
// BEHAVIOUR
// - Reset:
//   - all entries invalid, all outputs 0, sticky flags cleared.
//   - Reset asserted mid-operation discards every entry and issues no completion pulse.
// - Request capture (lce_req_v_i & lce_req_ready_and_i):
//   - Allocate the lowest-index free entry.
//   - Store blk = addr[paddr-1:offset], kind = msg_type: rd_miss, wr_miss, uc_rd or uc_wr; age = 0.
// - Command filter:
//   - Only handshaken commands with payload.dst_id == lce_id_i are examined.
//   - Others are ignored silently.
// - Completion commands:
//   - e_bedrock_cmd_data: retires rd_miss or wr_miss.
//   - e_bedrock_cmd_st_wakeup: retires wr_miss.
//   - e_bedrock_cmd_uc_data: retires uc_rd.
//   - e_bedrock_cmd_uc_st_done: retires uc_wr.
//   - All other command types (inv, set_state, tr, wb, ...) are not completions.
// - Matching:
//   - Candidate = valid entry with equal blk and compatible kind.
//   - If several candidates, the largest age retires; ties go to the lowest index.
//   - No candidate: set unmatched_o.
// - Latency:
//   - Completion pulse is registered, asserted in the cycle after the command handshake.
//   - cache_req_complete_o is driven for rd_miss, wr_miss and uc_rd; uc_store_req_complete_o for uc_wr.
//   - At most one retire per cycle.
// - Simultaneous request and completion in one cycle:
//   - Matching sees only pre-existing entries.
//   - The freed slot is not reused until the next cycle.
//   - A new request allocates from the slots that were free at the start of the cycle.
// - Full table: a request accepted while full is dropped, overflow_o is set, and outstanding_o stays max_outstanding_p.
// - Aging:
//   - Each valid entry increments age every cycle, saturating at timeout_p.
//   - When age becomes timeout_p: set timeout_o and $error with blk; the entry remains valid.
// - outstanding_o is the registered popcount of valid bits and updates the cycle after alloc/retire.
// - $error on request src_id != lce_id_i; the request is still captured.
// - Final: report any still-valid entries with blk and age.
// STRUCTURE
// - In bp_me_nonsynth_pkg:
//   - bp_me_nonsynth_req_kind_e (rd, wr, uc_rd, uc_wr)
//   - parameterized entry fields: valid, blk, kind, age
// - Free-slot selection: bsg_priority_encode.
// - Oldest-match selection: one sub-module, bp_me_nonsynth_oldest_select (max-age, lowest-index tiebreak, one-hot out).
// - Entry table: flops in this module.
// TESTING
// - rd_miss 0x8000_0040 at t, cmd_data 0x8000_0040 at t+20 -> cache_req_complete_o=1 at t+21 only; outstanding_o 1 then 0.
// - uc_wr 0x0010_0000, then cmd_uc_st_done -> uc_store_req_complete_o pulses once; cache_req_complete_o stays 0.
// - 4 requests fill table (max=4), 5th accepted -> overflow_o=1, outstanding_o=4; 4 completions -> 4 pulses, outstanding_o=0.
// - Two rd_miss to same block at t and t+3, one cmd_data -> entry allocated at t retires; second remains.
// - timeout_p=50, no reply -> timeout_o=1 at cycle 50 after allocation; cmd_data at 80 still retires and pulses.
// - cmd_data with no entry, or dst_id != lce_id_i -> unmatched_o=1 resp. no effect; reset mid-flight -> outstanding_o=0, no pulse.

Source files
------------

// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the BedRock LCE monitors.
//  - Configuration widths (physical address, LCE id, CCE block) for the
//    unicore-half style configuration these monitors are built against.
//  - LCE request / command message types (header only; data is not needed
//    by the monitors).
//  - Request kinds tracked by the request tracker and helpers that map
//    request types to kinds and decide which command retires which kind.
package bp_me_nonsynth_pkg;

  localparam int paddr_width_gp     = 40;
  localparam int lce_id_width_gp    = 4;
  localparam int cce_block_width_gp = 512;

  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0,
    e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3,
    e_bedrock_req_uc_amo  = 4'd4
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync        = 4'd0,
    e_bedrock_cmd_set_clear   = 4'd1,
    e_bedrock_cmd_inv         = 4'd2,
    e_bedrock_cmd_st          = 4'd3,
    e_bedrock_cmd_data        = 4'd4,
    e_bedrock_cmd_st_wakeup   = 4'd5,
    e_bedrock_cmd_wb          = 4'd6,
    e_bedrock_cmd_st_wb       = 4'd7,
    e_bedrock_cmd_tr          = 4'd8,
    e_bedrock_cmd_st_tr       = 4'd9,
    e_bedrock_cmd_st_tr_wb    = 4'd10,
    e_bedrock_cmd_uc_data     = 4'd11,
    e_bedrock_cmd_uc_st_done  = 4'd12
  } bp_bedrock_cmd_type_e;

  typedef enum logic [1:0] {
    e_kind_rd    = 2'd0,
    e_kind_wr    = 2'd1,
    e_kind_uc_rd = 2'd2,
    e_kind_uc_wr = 2'd3
  } bp_me_nonsynth_req_kind_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] src_id;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_lce_req_payload_s payload;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_req_type_e        msg_type;
  } bp_bedrock_lce_req_header_s;

  typedef struct packed {
    bp_bedrock_lce_req_header_s header;
  } bp_bedrock_lce_req_msg_s;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] dst_id;
    logic [lce_id_width_gp-1:0] src_id;
  } bp_bedrock_lce_cmd_payload_s;

  typedef struct packed {
    bp_bedrock_lce_cmd_payload_s payload;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_cmd_type_e        msg_type;
  } bp_bedrock_lce_cmd_header_s;

  typedef struct packed {
    bp_bedrock_lce_cmd_header_s header;
  } bp_bedrock_lce_cmd_msg_s;

  // Request type to tracked kind; unknown types are tracked as plain reads.
  function automatic bp_me_nonsynth_req_kind_e req_kind(input bp_bedrock_req_type_e t);
    case (t)
      e_bedrock_req_rd_miss: req_kind = e_kind_rd;
      e_bedrock_req_wr_miss: req_kind = e_kind_wr;
      e_bedrock_req_uc_rd:   req_kind = e_kind_uc_rd;
      e_bedrock_req_uc_wr:   req_kind = e_kind_uc_wr;
      default:               req_kind = e_kind_rd;
    endcase
  endfunction

  // True for the command types that can complete a request.
  function automatic logic cmd_is_completion(input bp_bedrock_cmd_type_e t);
    case (t)
      e_bedrock_cmd_data,
      e_bedrock_cmd_st_wakeup,
      e_bedrock_cmd_uc_data,
      e_bedrock_cmd_uc_st_done: cmd_is_completion = 1'b1;
      default:                  cmd_is_completion = 1'b0;
    endcase
  endfunction

  // True when command type t is allowed to retire an entry of kind k.
  function automatic logic cmd_retires(input bp_bedrock_cmd_type_e t,
                                       input bp_me_nonsynth_req_kind_e k);
    case (t)
      e_bedrock_cmd_data:       cmd_retires = (k == e_kind_rd) || (k == e_kind_wr);
      e_bedrock_cmd_st_wakeup:  cmd_retires = (k == e_kind_wr);
      e_bedrock_cmd_uc_data:    cmd_retires = (k == e_kind_uc_rd);
      e_bedrock_cmd_uc_st_done: cmd_retires = (k == e_kind_uc_wr);
      default:                  cmd_retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bp_me_nonsynth_oldest_select.sv
// Picks the oldest candidate entry.
//  cand_i        : per-entry candidate flags
//  age_i         : per-entry age
//  sel_one_hot_o : one-hot of the candidate with the largest age; equal ages
//                  resolve to the lowest index
//  v_o           : at least one candidate present
module bp_me_nonsynth_oldest_select
 #(parameter int els_p       = 4
  ,parameter int age_width_p = 8
  )
  (input  logic [els_p-1:0]                  cand_i
  ,input  logic [els_p-1:0][age_width_p-1:0] age_i
  ,output logic [els_p-1:0]                  sel_one_hot_o
  ,output logic                              v_o
  );

  logic [age_width_p-1:0] best_age_s;

  // Linear scan; strict greater-than keeps the earlier index on ties.
  always_comb begin
    sel_one_hot_o = '0;
    v_o           = 1'b0;
    best_age_s    = '0;
    for (int i = 0; i < els_p; i++) begin
      if (cand_i[i] && (!v_o || (age_i[i] > best_age_s))) begin
        sel_one_hot_o    = '0;
        sel_one_hot_o[i] = 1'b1;
        v_o              = 1'b1;
        best_age_s       = age_i[i];
      end else begin
        best_age_s = best_age_s;
      end
    end
  end

endmodule

// File: rtl/bp_me_nonsynth_lce_req_tracker.sv
// Monitor on one LCE's BedRock request/command interface.
// Every accepted LCE request is recorded in a small table keyed by block
// address and request kind; the matching completion command retires it and
// produces a registered completion pulse for the LCE tracer.
//  clk_i, reset_i               clock, synchronous active-high reset
//  lce_id_i                     id of the monitored LCE
//  lce_req_i/_v_i/_ready_and_i  request channel (LCE -> CCE)
//  lce_cmd_i/_v_i/_ready_and_i  command channel (CCE -> LCE)
//  cache_req_complete_o         pulse: cached or uncached-load request retired
//  uc_store_req_complete_o      pulse: uncached store retired
//  outstanding_o                number of valid table entries
//  timeout_o                    sticky: an entry reached timeout_p cycles
//  overflow_o                   sticky: request accepted while table full
//  unmatched_o                  sticky: completion matched no entry
// Address/id widths come from bp_me_nonsynth_pkg. report_p enables the
// simulation messages (timeouts, src_id mismatch, end-of-run leftovers).
module bp_me_nonsynth_lce_req_tracker
  import bp_me_nonsynth_pkg::*;
 #(parameter int max_outstanding_p = 4
  ,parameter int timeout_p         = 10000
  ,parameter int block_width_p     = cce_block_width_gp
  ,parameter bit report_p          = 1'b1
  ,localparam int cnt_width_lp     = $clog2(max_outstanding_p+1)
  )
  (input  logic                        clk_i
  ,input  logic                        reset_i
  ,input  logic [lce_id_width_gp-1:0]  lce_id_i
  ,input  bp_bedrock_lce_req_msg_s     lce_req_i
  ,input  logic                        lce_req_v_i
  ,input  logic                        lce_req_ready_and_i
  ,input  bp_bedrock_lce_cmd_msg_s     lce_cmd_i
  ,input  logic                        lce_cmd_v_i
  ,input  logic                        lce_cmd_ready_and_i
  ,output logic                        cache_req_complete_o
  ,output logic                        uc_store_req_complete_o
  ,output logic [cnt_width_lp-1:0]     outstanding_o
  ,output logic                        timeout_o
  ,output logic                        overflow_o
  ,output logic                        unmatched_o
  );

  localparam int offset_lp    = $clog2(block_width_p/8);
  localparam int blk_width_lp = paddr_width_gp - offset_lp;
  localparam int age_width_lp = $clog2(timeout_p+1);
  localparam logic [age_width_lp-1:0] timeout_age_lp = age_width_lp'(timeout_p);
  localparam logic [age_width_lp-1:0] pre_timeout_lp = age_width_lp'(timeout_p-1);

  // Entry table
  logic [max_outstanding_p-1:0]                   valid_r;
  logic [blk_width_lp-1:0]                        blk_r  [max_outstanding_p];
  bp_me_nonsynth_req_kind_e                       kind_r [max_outstanding_p];
  logic [max_outstanding_p-1:0][age_width_lp-1:0] age_r;

  logic                         req_fire_s, cmd_fire_s;
  logic                         alloc_s, overflow_set_s, retire_s, unmatched_set_s;
  logic                         full_s, match_v_s, timeout_set_s;
  bp_bedrock_cmd_type_e         cmd_type_s;
  logic [blk_width_lp-1:0]      req_blk_s, cmd_blk_s;
  logic [max_outstanding_p-1:0] cand_s, retire_oh_s, alloc_oh_s, valid_n_s;
  logic [cnt_width_lp-1:0]      count_n_s;
  logic                         unused_s;

  assign cmd_type_s = lce_cmd_i.header.msg_type;
  assign req_blk_s  = lce_req_i.header.addr[paddr_width_gp-1:offset_lp];
  assign cmd_blk_s  = lce_cmd_i.header.addr[paddr_width_gp-1:offset_lp];

  assign req_fire_s = lce_req_v_i & lce_req_ready_and_i;
  // Only completion-type commands addressed to this LCE are considered.
  assign cmd_fire_s = lce_cmd_v_i & lce_cmd_ready_and_i
                    & (lce_cmd_i.header.payload.dst_id == lce_id_i)
                    & cmd_is_completion(cmd_type_s);

  // Block offset bits and the command src_id carry nothing for matching.
  assign unused_s = ^{lce_req_i.header.addr, lce_cmd_i.header.addr,
                      lce_cmd_i.header.payload.src_id};

  // Candidates come from the table as it stood at the start of the cycle.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < max_outstanding_p; i++) begin
      cand_s[i] = valid_r[i] & (blk_r[i] == cmd_blk_s) & cmd_retires(cmd_type_s, kind_r[i]);
    end
  end

  bp_me_nonsynth_oldest_select
   #(.els_p(max_outstanding_p), .age_width_p(age_width_lp))
   oldest_select
    (.cand_i(cand_s)
    ,.age_i(age_r)
    ,.sel_one_hot_o(retire_oh_s)
    ,.v_o(match_v_s)
    );

  assign retire_s        = cmd_fire_s & match_v_s;
  assign unmatched_set_s = cmd_fire_s & ~match_v_s;

  // Lowest free slot: valid_r + 1 carries into the first zero bit of valid_r.
  assign full_s         = &valid_r;
  assign alloc_oh_s     = ~valid_r & (valid_r + max_outstanding_p'(1));
  assign alloc_s        = req_fire_s & ~full_s;
  assign overflow_set_s = req_fire_s & full_s;

  // Retire and allocate never touch the same slot (valid vs. free at cycle start).
  assign valid_n_s = (valid_r & ~({max_outstanding_p{retire_s}} & retire_oh_s))
                   | ({max_outstanding_p{alloc_s}} & alloc_oh_s);

  // Population count of next-state valid bits.
  always_comb begin
    count_n_s = '0;
    for (int i = 0; i < max_outstanding_p; i++) begin
      count_n_s = count_n_s + cnt_width_lp'(valid_n_s[i]);
    end
  end

  // An entry that stays valid and is one cycle short of the limit times out now.
  always_comb begin
    timeout_set_s = 1'b0;
    for (int i = 0; i < max_outstanding_p; i++) begin
      timeout_set_s = timeout_set_s
                    | (valid_r[i] & valid_n_s[i] & (age_r[i] == pre_timeout_lp));
    end
  end

  // Valid bits, completion pulses, count and sticky flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_r                 <= '0;
      cache_req_complete_o    <= 1'b0;
      uc_store_req_complete_o <= 1'b0;
      outstanding_o           <= '0;
      timeout_o               <= 1'b0;
      overflow_o              <= 1'b0;
      unmatched_o             <= 1'b0;
    end else begin
      valid_r                 <= valid_n_s;
      cache_req_complete_o    <= retire_s & (cmd_type_s != e_bedrock_cmd_uc_st_done);
      uc_store_req_complete_o <= retire_s & (cmd_type_s == e_bedrock_cmd_uc_st_done);
      outstanding_o           <= count_n_s;
      timeout_o               <= timeout_o | timeout_set_s;
      overflow_o              <= overflow_o | overflow_set_s;
      unmatched_o             <= unmatched_o | unmatched_set_s;
    end
  end

  // Entry payload and saturating age.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < max_outstanding_p; i++) begin
      if (reset_i) begin
        blk_r[i]  <= '0;
        kind_r[i] <= e_kind_rd;
        age_r[i]  <= '0;
      end else if (alloc_s && alloc_oh_s[i]) begin
        blk_r[i]  <= req_blk_s;
        kind_r[i] <= req_kind(lce_req_i.header.msg_type);
        age_r[i]  <= '0;
      end else if (valid_r[i] && (age_r[i] != timeout_age_lp)) begin
        age_r[i]  <= age_r[i] + age_width_lp'(1);
      end else begin
        age_r[i]  <= age_r[i];
      end
    end
  end

  // Simulation messages: foreign src_id on a request, entries timing out.
  always_ff @(posedge clk_i) begin
    if (report_p && !reset_i) begin
      if (req_fire_s && (lce_req_i.header.payload.src_id != lce_id_i)) begin
        $error("lce_req_tracker: request src_id %0d differs from lce_id %0d",
               lce_req_i.header.payload.src_id, lce_id_i);
      end
      for (int i = 0; i < max_outstanding_p; i++) begin
        if (valid_r[i] && valid_n_s[i] && (age_r[i] == pre_timeout_lp)) begin
          $error("lce_req_tracker: entry %0d blk %h timed out", i, blk_r[i]);
        end
      end
    end
  end

  // End-of-run listing of requests that never completed.
  final begin
    if (report_p) begin
      for (int i = 0; i < max_outstanding_p; i++) begin
        if (valid_r[i]) begin
          $warning("lce_req_tracker: entry %0d still outstanding blk %h age %0d",
                   i, blk_r[i], age_r[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_me_nonsynth_lce_req_tracker.sv
module tb_bp_me_nonsynth_lce_req_tracker;
  import bp_me_nonsynth_pkg::*;

  localparam int max_lp     = 4;
  localparam int timeout_lp = 50;
  localparam logic [lce_id_width_gp-1:0] my_id = 4'd2;

  logic                         clk = 1'b0;
  logic                         reset_i;
  bp_bedrock_lce_req_msg_s      lce_req_i;
  logic                         lce_req_v_i;
  logic                         lce_req_ready_and_i;
  bp_bedrock_lce_cmd_msg_s      lce_cmd_i;
  logic                         lce_cmd_v_i;
  logic                         lce_cmd_ready_and_i;
  logic                         cache_req_complete_o;
  logic                         uc_store_req_complete_o;
  logic [2:0]                   outstanding_o;
  logic                         timeout_o, overflow_o, unmatched_o;

  always #5 clk = ~clk;

  bp_me_nonsynth_lce_req_tracker
   #(.max_outstanding_p(max_lp), .timeout_p(timeout_lp),
     .block_width_p(cce_block_width_gp), .report_p(1'b0))
   dut
    (.clk_i(clk)
    ,.reset_i(reset_i)
    ,.lce_id_i(my_id)
    ,.lce_req_i(lce_req_i)
    ,.lce_req_v_i(lce_req_v_i)
    ,.lce_req_ready_and_i(lce_req_ready_and_i)
    ,.lce_cmd_i(lce_cmd_i)
    ,.lce_cmd_v_i(lce_cmd_v_i)
    ,.lce_cmd_ready_and_i(lce_cmd_ready_and_i)
    ,.cache_req_complete_o(cache_req_complete_o)
    ,.uc_store_req_complete_o(uc_store_req_complete_o)
    ,.outstanding_o(outstanding_o)
    ,.timeout_o(timeout_o)
    ,.overflow_o(overflow_o)
    ,.unmatched_o(unmatched_o)
    );

  typedef struct { int cyc; bit uc; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ta, tb;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (cache_req_complete_o || uc_store_req_complete_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: cyc=%0d cache=%b uc_store=%b, required no pulse",
                 cyc, cache_req_complete_o, uc_store_req_complete_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || uc_store_req_complete_o != mon_e.uc ||
            cache_req_complete_o == mon_e.uc) begin
          errors++;
          $display("FAIL pulse: cyc=%0d cache=%b uc_store=%b, required cyc=%0d uc_store=%b",
                   cyc, cache_req_complete_o, uc_store_req_complete_o, mon_e.cyc, mon_e.uc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      mon_e = exp_q.pop_front();
      $display("FAIL pulse_missing: no pulse at cyc=%0d uc_store=%b", mon_e.cyc, mon_e.uc);
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic set_req(input bp_bedrock_req_type_e t, input logic [39:0] a);
    lce_req_i = '0;
    lce_req_i.header.msg_type       = t;
    lce_req_i.header.addr           = a;
    lce_req_i.header.payload.src_id = my_id;
    lce_req_v_i = 1'b1;
  endtask

  task automatic set_cmd(input bp_bedrock_cmd_type_e t, input logic [39:0] a,
                         input logic [3:0] dst);
    lce_cmd_i = '0;
    lce_cmd_i.header.msg_type       = t;
    lce_cmd_i.header.addr           = a;
    lce_cmd_i.header.payload.dst_id = dst;
    lce_cmd_v_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lce_req_v_i = 1'b0;
    lce_cmd_v_i = 1'b0;
  endtask

  task automatic req(input bp_bedrock_req_type_e t, input logic [39:0] a);
    set_req(t, a);
    step();
  endtask

  // Completion expected: pulse in the cycle after the handshake edge.
  task automatic cmd(input bp_bedrock_cmd_type_e t, input logic [39:0] a, input bit uc);
    set_cmd(t, a, my_id);
    step();
    exp_q.push_back('{cyc, uc});
  endtask

  task automatic cmd_quiet(input bp_bedrock_cmd_type_e t, input logic [39:0] a,
                           input logic [3:0] dst);
    set_cmd(t, a, dst);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    lce_req_i = '0; lce_req_v_i = 1'b0; lce_req_ready_and_i = 1'b1;
    lce_cmd_i = '0; lce_cmd_v_i = 1'b0; lce_cmd_ready_and_i = 1'b1;
    idle(3);
    reset_i = 1'b0;

    // Reset state
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_unmatched", unmatched_o, 0);
    chk("rst_pulses", {cache_req_complete_o, uc_store_req_complete_o}, 0);

    // Cached read miss, completed 20 cycles later
    req(e_bedrock_req_rd_miss, 40'h00_8000_0040);
    chk("rd_outstanding_1", outstanding_o, 1);
    idle(19);
    cmd(e_bedrock_cmd_data, 40'h00_8000_0040, 1'b0);
    chk("rd_outstanding_0", outstanding_o, 0);

    // Uncached store
    req(e_bedrock_req_uc_wr, 40'h00_0010_0000);
    idle(2);
    cmd(e_bedrock_cmd_uc_st_done, 40'h00_0010_0000, 1'b1);
    chk("ucwr_outstanding_0", outstanding_o, 0);

    // Fill table, overflow, drain with each completion kind
    req(e_bedrock_req_rd_miss, 40'h00_0000_1000);
    req(e_bedrock_req_wr_miss, 40'h00_0000_2000);
    req(e_bedrock_req_uc_rd,   40'h00_0000_3000);
    req(e_bedrock_req_uc_wr,   40'h00_0000_4000);
    chk("full_outstanding", outstanding_o, 4);
    chk("full_no_overflow", overflow_o, 0);
    req(e_bedrock_req_rd_miss, 40'h00_0000_5000);
    chk("overflow_flag", overflow_o, 1);
    chk("overflow_outstanding", outstanding_o, 4);
    cmd(e_bedrock_cmd_st_wakeup, 40'h00_0000_2000, 1'b0);
    cmd(e_bedrock_cmd_data,      40'h00_0000_1000, 1'b0);
    cmd(e_bedrock_cmd_uc_data,   40'h00_0000_3000, 1'b0);
    cmd(e_bedrock_cmd_uc_st_done,40'h00_0000_4000, 1'b1);
    chk("drain_outstanding", outstanding_o, 0);
    chk("drain_unmatched", unmatched_o, 0);
    cmd_quiet(e_bedrock_cmd_data, 40'h00_0000_5000, my_id);
    chk("dropped_unmatched", unmatched_o, 1);
    rst();
    chk("rst2_flags", {timeout_o, overflow_o, unmatched_o}, 0);

    // Oldest wins over lowest index; then timeout and late completion
    req(e_bedrock_req_uc_rd, 40'h00_0000_7000);
    req(e_bedrock_req_rd_miss, 40'h00_0000_6000);
    ta = cyc;
    cmd(e_bedrock_cmd_uc_data, 40'h00_0000_7000, 1'b0);
    req(e_bedrock_req_rd_miss, 40'h00_0000_6010);
    tb = cyc;
    chk("same_blk_outstanding", outstanding_o, 2);
    cmd(e_bedrock_cmd_data, 40'h00_0000_6020, 1'b0);
    chk("oldest_outstanding", outstanding_o, 1);
    idle_until(tb + 49);
    chk("timeout_not_yet", timeout_o, 0);
    idle_until(tb + 50);
    chk("timeout_set", timeout_o, 1);
    chk("timeout_still_valid", outstanding_o, 1);
    idle_until(tb + 79);
    cmd(e_bedrock_cmd_data, 40'h00_0000_6000, 1'b0);
    chk("late_outstanding", outstanding_o, 0);
    chk("late_unmatched", unmatched_o, 0);
    if (ta == 0) chk("ta_seen", ta, 1);
    rst();

    // Foreign dst_id and non-completion commands are ignored
    req(e_bedrock_req_rd_miss, 40'h00_0000_A000);
    cmd_quiet(e_bedrock_cmd_data, 40'h00_0000_A000, 4'd3);
    cmd_quiet(e_bedrock_cmd_inv,  40'h00_0000_A000, my_id);
    chk("ignored_outstanding", outstanding_o, 1);
    chk("ignored_unmatched", unmatched_o, 0);
    cmd(e_bedrock_cmd_data, 40'h00_0000_A000, 1'b0);
    cmd_quiet(e_bedrock_cmd_data, 40'h00_0000_9000, my_id);
    chk("nomatch_unmatched", unmatched_o, 1);
    chk("nomatch_outstanding", outstanding_o, 0);
    rst();

    // Request and retire in the same cycle with a full table
    req(e_bedrock_req_rd_miss, 40'h00_0000_1000);
    req(e_bedrock_req_rd_miss, 40'h00_0000_2000);
    req(e_bedrock_req_rd_miss, 40'h00_0000_3000);
    req(e_bedrock_req_rd_miss, 40'h00_0000_4000);
    set_req(e_bedrock_req_rd_miss, 40'h00_0000_E000);
    cmd(e_bedrock_cmd_data, 40'h00_0000_1000, 1'b0);
    chk("same_cycle_full_overflow", overflow_o, 1);
    chk("same_cycle_full_outstanding", outstanding_o, 3);
    rst();

    // Request and retire in the same cycle with room
    req(e_bedrock_req_rd_miss, 40'h00_0000_C000);
    set_req(e_bedrock_req_wr_miss, 40'h00_0000_D000);
    cmd(e_bedrock_cmd_data, 40'h00_0000_C000, 1'b0);
    chk("same_cycle_outstanding", outstanding_o, 1);
    chk("same_cycle_no_overflow", overflow_o, 0);
    cmd(e_bedrock_cmd_st_wakeup, 40'h00_0000_D000, 1'b0);
    chk("same_cycle_drain", outstanding_o, 0);

    // Reset mid-flight: entry discarded, completion during reset ignored
    req(e_bedrock_req_rd_miss, 40'h00_0000_B000);
    set_cmd(e_bedrock_cmd_data, 40'h00_0000_B000, my_id);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("midrst_outstanding", outstanding_o, 0);
    chk("midrst_pulse", cache_req_complete_o, 0);
    cmd_quiet(e_bedrock_cmd_data, 40'h00_0000_B000, my_id);
    chk("midrst_unmatched", unmatched_o, 1);

    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
